// File: rtl/decoder_arbiter_ctrl.sv
// Round-robin front end for a shared (13,8) syndrome decoder: arbitrates two
// codeword requesters, waits for the external decoder, returns tagged results.
module decoder_arbiter_ctrl #(
  parameter int DEC_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [12:0]       a_cx,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [12:0]       b_cx,
  output logic              b_ready,
  output logic [12:0]       dec_cx,
  input  logic [7:0]        dec_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_d,
  output logic              out_src,
  output logic              out_err,
  output logic              busy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // state | meaning
  // IDLE  | arbitrating between A and B, readys live for the granted side
  // WAIT  | codeword driven on dec_cx, counting down decoder settle time
  // HOLD  | result presented on out_*, waiting for out_ready
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam int WCW = (DEC_WAIT > 1) ? $clog2(DEC_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(DEC_WAIT - 1);

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           src, err;
  logic           last_grant;     // 0 = A, 1 = B
  logic           pick_b;
  logic           a_xfer, b_xfer;
  logic           capture;
  logic [12:0]    sel_cx;

  function automatic logic syn_nz(input logic [12:0] cx);
    logic [4:0] s;
    s[0] = cx[0] ^ cx[1] ^ cx[2] ^ cx[4] ^ cx[5] ^ cx[6] ^ cx[8];
    s[1] = cx[0] ^ cx[1] ^ cx[6] ^ cx[9];
    s[2] = cx[4] ^ cx[6] ^ cx[10];
    s[3] = cx[2] ^ cx[3] ^ cx[4] ^ cx[11];
    s[4] = cx[0] ^ cx[12];
    return |s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    a_xfer    = 1'b0;
    b_xfer    = 1'b0;
    capture   = 1'b0;
    // B wins when alone, or when both ask and A had the last grant
    pick_b    = b_valid & (~a_valid | ~last_grant);
    case (state)
      IDLE: begin
        if (!reset) begin
          a_ready = a_valid & ~pick_b;
          b_ready = pick_b;
        end
        a_xfer = a_valid & a_ready;
        b_xfer = b_valid & b_ready;
        if (a_xfer || b_xfer) state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_cx = b_xfer ? b_cx : a_cx;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cx     <= '0;
      src        <= 1'b0;
      err        <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      out_d      <= '0;
      out_src    <= 1'b0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      word_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      if (a_xfer || b_xfer) begin
        dec_cx     <= sel_cx;
        src        <= b_xfer;
        err        <= syn_nz(sel_cx);
        last_grant <= b_xfer;
        wait_cnt   <= WAIT_LOAD;
      end else if (state == WAIT && !capture) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (capture) begin
        out_d     <= dec_d;
        out_src   <= src;
        out_err   <= err;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end

      // clear has priority over a coincident capture
      if (clr_cnt) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end else if (capture) begin
        if (word_cnt != '1)        word_cnt <= word_cnt + 1'b1;
        if (err && err_cnt != '1)  err_cnt  <= err_cnt + 1'b1;
      end
    end
  end

endmodule
